// File: rtl/regacc_pkg.sv
// Shared types for the 4x8 register-file access path: register index, data word
// and the payload handed from operand fetch to execute.
package regacc_pkg;

    localparam int REG_DATA_W = 8;
    localparam int REG_ADDR_W = 2;
    localparam int NREGS      = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] data_t;

    typedef struct packed {
        data_t     op_a;
        data_t     op_b;
        reg_addr_t rd;
        logic      wr_rd;
    } ex_payload_t;

    function automatic logic [NREGS-1:0] addr_onehot(input reg_addr_t a);
        logic [NREGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, cleared by writeback or flush,
// set by an accepted instruction that writes rd. Flags writebacks to idle registers.
module reg_scoreboard
    import regacc_pkg::*;
(
    input  logic             clk,
    input  logic             sync_rst_n,
    input  logic             clr_en,
    input  reg_addr_t        clr_addr,
    input  logic             flush_en,
    input  reg_addr_t        flush_addr,
    input  logic             set_en,
    input  reg_addr_t        set_addr,
    output logic [NREGS-1:0] pending,
    output logic             err
);

    logic [NREGS-1:0] pending_nxt;

    // Clears first, then set, so a same-index set/clear leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (clr_en)   pending_nxt[clr_addr]   = 1'b0;
        if (flush_en) pending_nxt[flush_addr] = 1'b0;
        if (set_en)   pending_nxt[set_addr]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            pending <= '0;
            err     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (clr_en && !pending[clr_addr])
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file for decoded instructions, bypasses
// same-cycle writeback, stalls on RAW/WAW hazards and registers operands for execute.
module operand_fetch
    import regacc_pkg::*;
#(
    parameter int DATA_W      = REG_DATA_W,
    parameter int ADDR_W      = REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   sync_rst_n,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [ADDR_W-1:0]      dec_rs_a,
    input  logic                   dec_use_a,
    input  logic [ADDR_W-1:0]      dec_rs_b,
    input  logic                   dec_use_b,
    input  logic [ADDR_W-1:0]      dec_rd,
    input  logic                   dec_wr_rd,
    output logic                   rf_read_en_A,
    output logic [ADDR_W-1:0]      rf_addr_read_A,
    output logic                   rf_read_en_B,
    output logic [ADDR_W-1:0]      rf_addr_read_B,
    input  logic [DATA_W-1:0]      rf_data_out_A,
    input  logic [DATA_W-1:0]      rf_data_out_B,
    output logic                   rf_write_en,
    output logic [ADDR_W-1:0]      rf_addr_write,
    output logic [DATA_W-1:0]      rf_data_in,
    input  logic                   wb_valid,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [DATA_W-1:0]      ex_op_a,
    output logic [DATA_W-1:0]      ex_op_b,
    output logic [ADDR_W-1:0]      ex_rd,
    output logic                   ex_wr_rd,
    input  logic                   flush,
    output logic                   sb_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] sel_operand(input logic use_op, input logic wb_hit,
                                                      input logic [DATA_W-1:0] fwd,
                                                      input logic [DATA_W-1:0] rf);
        if (!use_op)
            return '0;
        return wb_hit ? fwd : rf;
    endfunction

    logic [NREGS-1:0]       pending;
    logic [NREGS-1:0]       wb_mask;
    logic [NREGS-1:0]       pend_eff;
    logic                   hazard;
    logic                   accept;
    logic                   wb_hit_a;
    logic                   wb_hit_b;
    ex_payload_t            pay_p0;
    ex_payload_t            ex_pay_p1;
    logic                   ex_vld_p1;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign rf_read_en_A   = dec_valid & dec_use_a;
    assign rf_addr_read_A = dec_rs_a;
    assign rf_read_en_B   = dec_valid & dec_use_b;
    assign rf_addr_read_B = dec_rs_b;

    assign rf_write_en    = wb_valid;
    assign rf_addr_write  = wb_addr;
    assign rf_data_in     = wb_data;

    // A writeback landing this cycle satisfies a RAW read but not a WAW claim.
    assign wb_mask  = wb_valid ? addr_onehot(wb_addr) : '0;
    assign pend_eff = pending & ~wb_mask;
    assign hazard   = (dec_use_a & pend_eff[dec_rs_a]) |
                      (dec_use_b & pend_eff[dec_rs_b]) |
                      (dec_wr_rd & pending[dec_rd]);

    assign dec_ready = (!ex_vld_p1 || ex_ready) && !hazard && !flush;
    assign accept    = dec_valid & dec_ready;

    assign wb_hit_a = wb_valid && (wb_addr == dec_rs_a);
    assign wb_hit_b = wb_valid && (wb_addr == dec_rs_b);

    // Stage p0 -> p1: operand capture into the execute register.
    always_comb begin
        pay_p0.op_a  = sel_operand(dec_use_a, wb_hit_a, wb_data, rf_data_out_A);
        pay_p0.op_b  = sel_operand(dec_use_b, wb_hit_b, wb_data, rf_data_out_B);
        pay_p0.rd    = dec_rd;
        pay_p0.wr_rd = dec_wr_rd;
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            ex_vld_p1 <= 1'b0;
            ex_pay_p1 <= '0;
        end else if (flush) begin
            ex_vld_p1 <= 1'b0;
        end else if (accept) begin
            ex_vld_p1 <= 1'b1;
            ex_pay_p1 <= pay_p0;
        end else if (ex_ready) begin
            ex_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n)
            stall_cnt_q <= '0;
        else if (dec_valid && !dec_ready)
            stall_cnt_q <= sat_inc(stall_cnt_q);
    end

    reg_scoreboard u_sb (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clr_en     (wb_valid),
        .clr_addr   (wb_addr),
        .flush_en   (flush & ex_vld_p1 & ex_pay_p1.wr_rd),
        .flush_addr (ex_pay_p1.rd),
        .set_en     (accept & dec_wr_rd),
        .set_addr   (dec_rd),
        .pending    (pending),
        .err        (sb_err)
    );

    assign ex_valid  = ex_vld_p1;
    assign ex_op_a   = ex_pay_p1.op_a;
    assign ex_op_b   = ex_pay_p1.op_b;
    assign ex_rd     = ex_pay_p1.rd;
    assign ex_wr_rd  = ex_pay_p1.wr_rd;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small behavioural register file attached.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        sync_rst_n;
    logic        dec_valid, dec_ready;
    logic [1:0]  dec_rs_a, dec_rs_b, dec_rd;
    logic        dec_use_a, dec_use_b, dec_wr_rd;
    logic        rf_read_en_A, rf_read_en_B, rf_write_en;
    logic [1:0]  rf_addr_read_A, rf_addr_read_B, rf_addr_write;
    logic [7:0]  rf_data_out_A, rf_data_out_B, rf_data_in;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        ex_valid, ex_ready, ex_wr_rd;
    logic [7:0]  ex_op_a, ex_op_b;
    logic [1:0]  ex_rd;
    logic        flush, sb_err;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] rf [4] = '{8'h00, 8'h11, 8'h22, 8'h00};

    assign rf_data_out_A = rf[rf_addr_read_A];
    assign rf_data_out_B = rf[rf_addr_read_B];
    always @(posedge clk) if (rf_write_en) rf[rf_addr_write] <= rf_data_in;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .sync_rst_n(sync_rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs_a(dec_rs_a), .dec_use_a(dec_use_a),
        .dec_rs_b(dec_rs_b), .dec_use_b(dec_use_b),
        .dec_rd(dec_rd), .dec_wr_rd(dec_wr_rd),
        .rf_read_en_A(rf_read_en_A), .rf_addr_read_A(rf_addr_read_A),
        .rf_read_en_B(rf_read_en_B), .rf_addr_read_B(rf_addr_read_B),
        .rf_data_out_A(rf_data_out_A), .rf_data_out_B(rf_data_out_B),
        .rf_write_en(rf_write_en), .rf_addr_write(rf_addr_write), .rf_data_in(rf_data_in),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd), .ex_wr_rd(ex_wr_rd),
        .flush(flush), .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    task automatic set_dec(input logic v, input logic [1:0] ra, input logic ua,
                           input logic [1:0] rb, input logic ub,
                           input logic [1:0] rd, input logic wr);
        dec_valid = v; dec_rs_a = ra; dec_use_a = ua;
        dec_rs_b = rb; dec_use_b = ub; dec_rd = rd; dec_wr_rd = wr;
    endtask

    task automatic test_reset;
        sync_rst_n = 1'b0; flush = 1'b1; ex_ready = 1'b1; wb_valid = 1'b0;
        wb_addr = 2'd0; wb_data = 8'h00;
        set_dec(1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 2'd3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %b want 0", ex_valid); end
        checks++; if (ex_op_a !== 8'h00) begin errors++; $display("FAIL rst_op_a got %h want 00", ex_op_a); end
        checks++; if (ex_op_b !== 8'h00) begin errors++; $display("FAIL rst_op_b got %h want 00", ex_op_b); end
        checks++; if (ex_rd !== 2'd0 || ex_wr_rd !== 1'b0) begin errors++; $display("FAIL rst_rd got %0d/%b want 0/0", ex_rd, ex_wr_rd); end
        checks++; if (dut.u_sb.pending !== 4'b0000) begin errors++; $display("FAIL rst_pending got %b want 0000", dut.u_sb.pending); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err got %b want 0", sb_err); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
        @(negedge clk);
        sync_rst_n = 1'b1; flush = 1'b0; dec_valid = 1'b0;
    endtask

    task automatic test_basic;
        @(negedge clk);
        set_dec(1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 2'd3, 1'b1);
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", dec_ready); end
        checks++; if ({rf_read_en_A, rf_addr_read_A, rf_read_en_B, rf_addr_read_B} !== {1'b1, 2'd1, 1'b1, 2'd2})
            begin errors++; $display("FAIL basic_rf_read got %b%0d %b%0d want 11 12", rf_read_en_A, rf_addr_read_A, rf_read_en_B, rf_addr_read_B); end
        @(posedge clk); #1;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL basic_ex_valid got %b want 1", ex_valid); end
        checks++; if (ex_op_a !== 8'h11) begin errors++; $display("FAIL basic_op_a got %h want 11", ex_op_a); end
        checks++; if (ex_op_b !== 8'h22) begin errors++; $display("FAIL basic_op_b got %h want 22", ex_op_b); end
        checks++; if (ex_rd !== 2'd3 || ex_wr_rd !== 1'b1) begin errors++; $display("FAIL basic_rd got %0d/%b want 3/1", ex_rd, ex_wr_rd); end
        checks++; if (dut.u_sb.pending !== 4'b1000) begin errors++; $display("FAIL basic_pending got %b want 1000", dut.u_sb.pending); end
        @(negedge clk);
        dec_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", ex_valid); end
    endtask

    task automatic test_raw_stall;
        @(negedge clk);
        set_dec(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_ready got %b want 0", dec_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL raw_stall_cnt got %0d want 3", stall_cnt); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL raw_ex_idle got %b want 0", ex_valid); end
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 2'd3; wb_data = 8'h5A;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %b want 1", dec_ready); end
        checks++; if ({rf_write_en, rf_addr_write, rf_data_in} !== {1'b1, 2'd3, 8'h5A})
            begin errors++; $display("FAIL raw_rf_write got %b %0d %h want 1 3 5a", rf_write_en, rf_addr_write, rf_data_in); end
        @(posedge clk); #1;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL raw_ex_valid got %b want 1", ex_valid); end
        checks++; if (ex_op_a !== 8'h5A) begin errors++; $display("FAIL raw_bypass_a got %h want 5a", ex_op_a); end
        checks++; if (ex_op_b !== 8'h00 || ex_wr_rd !== 1'b0) begin errors++; $display("FAIL raw_op_b got %h/%b want 00/0", ex_op_b, ex_wr_rd); end
        checks++; if (dut.u_sb.pending !== 4'b0000) begin errors++; $display("FAIL raw_pending got %b want 0000", dut.u_sb.pending); end
        checks++; if (stall_cnt !== 16'd3 || sb_err !== 1'b0) begin errors++; $display("FAIL raw_after got %0d/%b want 3/0", stall_cnt, sb_err); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        wb_valid = 1'b0; ex_ready = 1'b0;
        set_dec(1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 2'd0, 1'b1);
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", dec_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (ex_valid !== 1'b1 || ex_op_a !== 8'h5A)
                begin errors++; $display("FAIL bp_hold%0d got %b/%h want 1/5a", i, ex_valid, ex_op_a); end
        end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL bp_stall_cnt got %0d want 6", stall_cnt); end
        @(negedge clk);
        ex_ready = 1'b1;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got %b want 1", dec_ready); end
        @(posedge clk); #1;
        checks++; if (ex_valid !== 1'b1 || ex_op_a !== 8'h11 || ex_op_b !== 8'h22)
            begin errors++; $display("FAIL bp_resume got %b/%h/%h want 1/11/22", ex_valid, ex_op_a, ex_op_b); end
        checks++; if (ex_rd !== 2'd0 || ex_wr_rd !== 1'b1) begin errors++; $display("FAIL bp_rd got %0d/%b want 0/1", ex_rd, ex_wr_rd); end
        checks++; if (dut.u_sb.pending !== 4'b0001) begin errors++; $display("FAIL bp_pending got %b want 0001", dut.u_sb.pending); end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL bp_stall_final got %0d want 6", stall_cnt); end
        @(negedge clk);
        dec_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", ex_valid); end
    endtask

    task automatic test_flush;
        @(negedge clk);
        set_dec(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
        wb_valid = 1'b1; wb_addr = 2'd0; wb_data = 8'h99;
        @(posedge clk); #1;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 2'd1 || ex_op_a !== 8'h00)
            begin errors++; $display("FAIL fl_issue got %b/%0d/%h want 1/1/00", ex_valid, ex_rd, ex_op_a); end
        checks++; if (dut.u_sb.pending !== 4'b0010 || sb_err !== 1'b0)
            begin errors++; $display("FAIL fl_pending got %b/%b want 0010/0", dut.u_sb.pending, sb_err); end
        @(negedge clk);
        wb_valid = 1'b0; dec_valid = 1'b0; flush = 1'b1; ex_ready = 1'b0;
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b want 0", dec_ready); end
        @(posedge clk); #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_ex_valid got %b want 0", ex_valid); end
        checks++; if (dut.u_sb.pending !== 4'b0000 || sb_err !== 1'b0)
            begin errors++; $display("FAIL fl_clear got %b/%b want 0000/0", dut.u_sb.pending, sb_err); end
        @(negedge clk);
        flush = 1'b0; ex_ready = 1'b1; wb_valid = 1'b1; wb_addr = 2'd1; wb_data = 8'h77;
        @(posedge clk); #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL fl_sb_err got %b want 1", sb_err); end
        @(negedge clk);
        wb_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL fl_sticky got %b want 1", sb_err); end
    endtask

    // Writeback to an idle r2 in the same cycle an instruction claims r2: the
    // claim survives, operand B takes the bypassed value, and the idle write is flagged.
    task automatic test_collide;
        @(negedge clk);
        set_dec(1'b1, 2'd1, 1'b1, 2'd2, 1'b1, 2'd2, 1'b1);
        wb_valid = 1'b1; wb_addr = 2'd2; wb_data = 8'h33;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL col_ready got %b want 1", dec_ready); end
        @(posedge clk); #1;
        checks++; if (dut.u_sb.pending !== 4'b0100) begin errors++; $display("FAIL col_pending got %b want 0100", dut.u_sb.pending); end
        checks++; if (ex_op_a !== 8'h77 || ex_op_b !== 8'h33)
            begin errors++; $display("FAIL col_ops got %h/%h want 77/33", ex_op_a, ex_op_b); end
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL col_sb_err got %b want 1", sb_err); end
        @(negedge clk);
        wb_valid = 1'b0; dec_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw_stall();
        test_backpressure();
        test_flush();
        test_reset();
        test_collide();
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
